mont_exp_ctrl: RTL

- Requester side of the Montgomery multiplier start/done interface.
- Runs left-to-right square-and-multiply modular exponentiation by issuing operand pairs to an external Montgomery multiplier core and consuming its result/done.
- Operates entirely in the Montgomery domain: caller supplies x~ = x·R mod M and R mod M; result is x^e·R mod M.
- Sits between the top-level RSA sequencer and one multiplier instance.

---
 rtl/mont_exp_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation controller in the Montgomery domain.
// Drives one external Montgomery multiplier through a start/done handshake.
module mont_exp_ctrl #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0] in_e,
  input  logic [CNT_W-1:0] in_e_len,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_m,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, x, e, m, result_q;
  logic [CNT_W-1:0] idx;
  logic             done_q, mm_start_q, mul_sel;
  logic             issue_nxt, mul_nxt;
  logic             e_bit, idx_zero;

  assign e_bit    = |(e & (WIDTH'(1) << idx));
  assign idx_zero = (idx == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (in_e_len == '0) ? FINISH : SQ_ISSUE;
      end
      SQ_ISSUE: state_nxt = SQ_WAIT;
      SQ_WAIT: begin
        if (mm_done) begin
          if (e_bit)         state_nxt = MUL_ISSUE;
          else if (idx_zero) state_nxt = FINISH;
          else               state_nxt = SQ_ISSUE;
        end
      end
      MUL_ISSUE: state_nxt = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done) state_nxt = idx_zero ? FINISH : SQ_ISSUE;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start pulse and operand-B select are flopped from the next state so they never glitch.
  always_comb begin
    issue_nxt = 1'b0;
    mul_nxt   = 1'b0;
    case (state_nxt)
      SQ_ISSUE:  issue_nxt = 1'b1;
      MUL_ISSUE: begin
        issue_nxt = 1'b1;
        mul_nxt   = 1'b1;
      end
      MUL_WAIT:  mul_nxt = 1'b1;
      default: begin
        issue_nxt = 1'b0;
        mul_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mm_start_q <= 1'b0;
      mul_sel    <= 1'b0;
      done_q     <= 1'b0;
      acc        <= '0;
      x          <= '0;
      e          <= '0;
      m          <= '0;
      idx        <= '0;
      result_q   <= '0;
    end else begin
      state      <= state_nxt;
      mm_start_q <= issue_nxt;
      mul_sel    <= mul_nxt;
      done_q     <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            x   <= in_x;
            e   <= in_e;
            m   <= in_m;
            acc <= in_r;
            idx <= in_e_len - CNT_W'(1);
          end
        end
        SQ_WAIT: begin
          if (mm_done) begin
            acc <= mm_result;
            if (!e_bit && !idx_zero) idx <= idx - CNT_W'(1);
          end
        end
        MUL_WAIT: begin
          if (mm_done) begin
            acc <= mm_result;
            if (!idx_zero) idx <= idx - CNT_W'(1);
          end
        end
        FINISH:  result_q <= acc;
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE) || done_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_start = mm_start_q;
  assign mm_a     = acc;
  assign mm_b     = mul_sel ? x : acc;
  assign mm_m     = m;

endmodule
